param_register_file: RTL
========================

Name: param_register_file

Overview:
Parametrised next-generation register file for the single-cycle/multicycle MIPS datapath.
- Generalises width, depth and read-port count.
- Adds a dedicated link-register write port for jal, a hardwired zero register, and write-to-read bypass.
- Adds a handshaked dump engine that streams the whole register array to the debug/trace logger, replacing file-dump side effects.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; depth = 2**ADDR_W
LINK_REG, 31, index written by the link port
RESET_INDEX, 1, 1: register i resets to value i (zero-extended, truncated to DATA_W); 0: all registers reset to 0

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
rs_addr  in  ADDR_W  read port A address
rt_addr  in  ADDR_W  read port B address
rs_data  out  DATA_W  read port A data, registered
rt_data  out  DATA_W  read port B data, registered
reg_write  in  1  general write enable
rd_addr  in  ADDR_W  general write address
write_data  in  DATA_W  general write data
link_write  in  1  link write enable (jal)
link_data  in  DATA_W  return address written to LINK_REG
dump_start  in  1  single-cycle request to stream all registers
dump_valid  out  1  dump beat valid
dump_ready  in  1  consumer accepts beat
dump_addr  out  ADDR_W  index of current beat
dump_data  out  DATA_W  value of current beat
dump_busy  out  1  dump engine not IDLE
dump_done  out  1  one-cycle pulse after last beat is accepted

Behaviour:
- Reset (async assert, sync release):
  - array loaded per RESET_INDEX; register 0 is always 0.
  - rs_data/rt_data = 0; dump_valid/busy/done = 0; dump_addr/dump_data = 0; FSM = IDLE.
- Writes commit on the rising edge:
  - general write when reg_write=1 and rd_addr!=0.
  - link write when link_write=1 and LINK_REG!=0.
  - both target LINK_REG in the same cycle -> link_data wins.
  - any write to address 0 is dropped.
- Reads: rs_data/rt_data update at each rising edge with register[addr], 1-cycle latency.
- Bypass: if a write in the same cycle targets rs_addr/rt_addr (nonzero), the registered output takes the new write value, following link-over-general priority. Address 0 always reads 0.
- Dump FSM states: IDLE, LOAD, BEAT, DONE.
  - IDLE: dump_start=1 -> LOAD with index 0. dump_start while busy is ignored.
  - LOAD: capture register[index] (with bypass of same-cycle writes) into dump_data; set dump_addr=index and dump_valid=1 -> BEAT.
  - BEAT: dump_data/dump_addr held stable while dump_valid && !dump_ready, even if the register is written meanwhile.
  - BEAT, on dump_ready: if index = depth-1 -> DONE, dump_valid=0; else index+1 -> LOAD.
  - DONE: dump_done=1 for one cycle -> IDLE.
  - Throughput: one beat per 2 cycles; a full dump with ready tied high takes 2*depth+1 cycles from the start edge to the done pulse.
  - Dump never stalls reads or writes.
- Reset mid-dump: FSM returns to IDLE immediately, no done pulse, array reloaded.
- Index counter is ADDR_W+1 bits wide, so depth-1 never wraps to 0.

Decomposition:
- Shared package rf_pkg holds:
  - dump FSM state typedef (IDLE/LOAD/BEAT/DONE).
  - default DATA_W/ADDR_W constants.
  - LINK_REG default 31 and ZERO_REG 0.
- One sub-module is natural: rf_dump_ctrl, containing the FSM, index counter and handshake. It sees the array through a read-address/read-data pair plus the bypass inputs. The array, write priority and read ports stay in the top level.

Test Plan:
- Reset with RESET_INDEX=1; read rs_addr=5, rt_addr=3 -> next cycle rs_data=5, rt_data=3. Read address 0 -> 0.
- reg_write=1, rd_addr=6, write_data=300, rs_addr=6 in the same cycle -> rs_data=300 the next cycle (bypass). rd_addr=0, write_data=0xFFFF -> register 0 still reads 0.
- reg_write to 31 with 0x1111 and link_write with link_data=0x00400024 in the same cycle -> register 31 = 0x00400024.
- dump_start with dump_ready=1 -> 32 beats, dump_addr 0..31, dump_data matches the array. dump_done pulses exactly once, 65 cycles after the start edge.
- dump_ready held low 10 cycles at beat 4, while register 4 is written 0xABCD -> dump_data stays the old value and is stable throughout. The next dump shows 0xABCD.
- Assert reset during beat 17 -> dump_valid and dump_busy drop immediately, no dump_done pulse, registers return to their index values.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared types and default sizing for the parametrised MIPS register file
// and its debug dump engine.
package rf_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_LINK_REG = 31;
    localparam int ZERO_REG     = 0;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        BEAT,
        DONE
    } dump_state_t;

endpackage

// File: rtl/rf_dump_ctrl.sv
// Dump engine: walks every register index and presents each value on a
// valid/ready stream, one beat per two cycles, then pulses dump_done.
module rf_dump_ctrl
    import rf_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int LINK_REG = DEF_LINK_REG
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              dump_start,
    input  logic              dump_ready,
    output logic              dump_valid,
    output logic              dump_busy,
    output logic              dump_done,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data,
    output logic [ADDR_W-1:0] array_addr,
    input  logic [DATA_W-1:0] array_data,
    input  logic              gen_we,
    input  logic [ADDR_W-1:0] gen_addr,
    input  logic [DATA_W-1:0] gen_data,
    input  logic              link_we,
    input  logic [DATA_W-1:0] link_data
);

    localparam int DEPTH = 1 << ADDR_W;

    dump_state_t       state;
    dump_state_t       state_next;
    logic [ADDR_W:0]   index;
    logic              last_beat;
    logic              capture;
    logic              accept;
    logic [DATA_W-1:0] load_value;

    assign array_addr = index[ADDR_W-1:0];
    assign last_beat  = (index == (ADDR_W+1)'(DEPTH - 1));

    // A write landing in the LOAD cycle must be visible in the captured beat.
    always_comb begin
        if (array_addr == ADDR_W'(ZERO_REG))
            load_value = '0;
        else if (link_we && array_addr == ADDR_W'(LINK_REG))
            load_value = link_data;
        else if (gen_we && array_addr == gen_addr)
            load_value = gen_data;
        else
            load_value = array_data;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // NOTE: every comb output gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (dump_start) state_next = LOAD;
            LOAD:    state_next = BEAT;
            BEAT:    if (dump_ready) state_next = last_beat ? DONE : LOAD;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        dump_busy = (state != IDLE);
        capture   = (state == LOAD);
        accept    = (state == BEAT) && dump_ready;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            index      <= '0;
            dump_valid <= 1'b0;
            dump_addr  <= '0;
            dump_data  <= '0;
            dump_done  <= 1'b0;
        end else begin
            dump_done <= (state == DONE);
            if (state == IDLE && dump_start)
                index <= '0;
            if (capture) begin
                dump_valid <= 1'b1;
                dump_addr  <= array_addr;
                dump_data  <= load_value;
            end else if (accept) begin
                dump_valid <= 1'b0;
                if (!last_beat)
                    index <= index + 1'b1;
            end
        end
    end

endmodule

// File: rtl/param_register_file.sv
// Parametrised MIPS register file: two registered read ports with write
// bypass, general + link write ports, hardwired zero register, dump engine.
module param_register_file
    import rf_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int LINK_REG    = DEF_LINK_REG,
    parameter int RESET_INDEX = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] write_data,
    input  logic              link_write,
    input  logic [DATA_W-1:0] link_data,
    input  logic              dump_start,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_busy,
    output logic              dump_done
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic              gen_we;
    logic              link_we;
    logic [ADDR_W-1:0] dump_rd_addr;

    assign gen_we  = reg_write && (rd_addr != ADDR_W'(ZERO_REG));
    assign link_we = link_write && (LINK_REG != ZERO_REG);

    function automatic logic [DATA_W-1:0] read_bypass(input logic [ADDR_W-1:0] addr,
                                                      input logic [DATA_W-1:0] stored);
        if (addr == ADDR_W'(ZERO_REG))
            return '0;
        else if (link_we && addr == ADDR_W'(LINK_REG))
            return link_data;
        else if (gen_we && addr == rd_addr)
            return write_data;
        else
            return stored;
    endfunction

    // NOTE: the array carries a reset image, so it is built from flops
    // rather than a RAM macro; that is what makes the reload possible.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= (RESET_INDEX != 0 && i != ZERO_REG) ? DATA_W'(i) : '0;
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                if (link_we && i == LINK_REG)
                    regs[i] <= link_data;
                else if (gen_we && rd_addr == ADDR_W'(i))
                    regs[i] <= write_data;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rs_data <= '0;
            rt_data <= '0;
        end else begin
            rs_data <= read_bypass(rs_addr, regs[rs_addr]);
            rt_data <= read_bypass(rt_addr, regs[rt_addr]);
        end
    end

    rf_dump_ctrl #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .LINK_REG (LINK_REG)
    ) u_dump_ctrl (
        .clock      (clock),
        .reset      (reset),
        .dump_start (dump_start),
        .dump_ready (dump_ready),
        .dump_valid (dump_valid),
        .dump_busy  (dump_busy),
        .dump_done  (dump_done),
        .dump_addr  (dump_addr),
        .dump_data  (dump_data),
        .array_addr (dump_rd_addr),
        .array_data (regs[dump_rd_addr]),
        .gen_we     (gen_we),
        .gen_addr   (rd_addr),
        .gen_data   (write_data),
        .link_we    (link_we),
        .link_data  (link_data)
    );

endmodule
